pc_unit: RTL and testbench

- Parametrised program counter for the vcpu fetch stage; drives the instruction address each cycle.
- Adds to the basic counter: configurable width and step, a stall input, a PC-relative branch, an absolute jump, and call/return through an internal return-address stack (RAS).
- Sits between the control/branch logic and instruction memory.
- Fully synchronous: one clock, no combinational paths from inputs to outputs.

---
 rtl/pc_unit.sv | 117 +++++++++++
 tb/tb_pc_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter with relative branch, absolute jump and call/return via a circular RAS.
// Optional macro PC_ALIGN_CHECK_EN: clears low target bits on taken transfers and pulses misaligned.
module pc_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter int                    INSTR_BYTES = 4,
    parameter int                    RAS_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  set,
    input  logic [ADDR_WIDTH-1:0] address_offset,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  call,
    input  logic                  ret,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_error,
    output logic                  misaligned
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [CW-1:0]         FULL_CNT = CW'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] pc, pc_next, seq_pc, target;
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]         wr_ptr, ptr_next, top_ptr;
    logic [CW-1:0]         count, count_next;
    logic                  push, pop, err_next;

    assign seq_pc              = pc + STEP;
    assign top_ptr             = wr_ptr - PW'(1);
    assign instruction_address = pc;

    // Data inputs are only selected under their own enable so X on them stays out of state.
    always_comb begin
        target     = pc;
        push       = 1'b0;
        pop        = 1'b0;
        err_next   = 1'b0;
        ptr_next   = wr_ptr;
        count_next = count;
        if (!stall) begin
            if (ret) begin
                if (count != '0) begin
                    target = ras_mem[top_ptr];
                    pop    = 1'b1;
                end else begin
                    target   = seq_pc;
                    err_next = 1'b1;
                end
            end else if (jump) begin
                target = jump_target;
                push   = call;
            end else if (set) begin
                target = pc + address_offset;
                push   = call;
            end else begin
                target = seq_pc;
            end
        end
        // Pushing while full overwrites the oldest slot, which wr_ptr already points at.
        if (push) begin
            ptr_next = wr_ptr + PW'(1);
            if (count == FULL_CNT) err_next = 1'b1;
            else                   count_next = count + CW'(1);
        end else if (pop) begin
            ptr_next   = top_ptr;
            count_next = count - CW'(1);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic taken, mis_next;
    assign taken    = !stall && (ret ? (count != '0) : (jump || set));
    assign mis_next = taken && ((target & LOW_MASK) != '0);
    assign pc_next  = taken ? (target & ~LOW_MASK) : target;

    always_ff @(posedge clock) begin
        if (!reset) misaligned <= 1'b0;
        else        misaligned <= mis_next;
    end
`else
    assign pc_next    = target;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc        <= RESET_ADDR;
            wr_ptr    <= '0;
            count     <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ras_error <= 1'b0;
        end else begin
            pc        <= pc_next;
            wr_ptr    <= ptr_next;
            count     <= count_next;
            ras_empty <= (count_next == '0);
            ras_full  <= (count_next == FULL_CNT);
            ras_error <= ras_error | err_next;
        end
    end

    // Storage needs no reset; only the pointer and count define its contents.
    always_ff @(posedge clock) begin
        if (reset && push) ras_mem[wr_ptr] <= seq_pc;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        set = 1'b0;
    logic [31:0] address_offset = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] instruction_address;
    logic        ras_empty, ras_full, ras_error, misaligned;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .set(set),
        .address_offset(address_offset), .jump(jump), .jump_target(jump_target),
        .call(call), .ret(ret), .instruction_address(instruction_address),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_error(ras_error),
        .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        stall = 0; set = 0; jump = 0; call = 0; ret = 0;
        address_offset = '0; jump_target = '0;
    endtask

    task automatic goto(input logic [31:0] a);
        idle(); jump = 1; jump_target = a; tick(); idle();
    endtask

    task automatic do_reset();
        idle(); reset = 0; tick(); reset = 1;
    endtask

    task automatic test_reset();
        idle(); reset = 0; tick(); tick();
        total++; if (instruction_address !== 32'h0) begin bad++; $display("FAIL reset_pc got %h exp %h", instruction_address, 32'h0); end
        total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got %b exp 1", ras_empty); end
        total++; if (ras_full !== 1'b0) begin bad++; $display("FAIL reset_full got %b exp 0", ras_full); end
        total++; if (ras_error !== 1'b0) begin bad++; $display("FAIL reset_error got %b exp 0", ras_error); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got %b exp 0", misaligned); end
        reset = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (instruction_address !== 32'(4 * i)) begin bad++; $display("FAIL seq_%0d got %h exp %h", i, instruction_address, 32'(4 * i)); end
        end
        total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL seq_empty got %b exp 1", ras_empty); end
    endtask

    task automatic test_stall_branch();
        goto(32'h10);
        stall = 1; set = 1; address_offset = 32'h100; tick();
        total++; if (instruction_address !== 32'h10) begin bad++; $display("FAIL stall_hold got %h exp %h", instruction_address, 32'h10); end
        stall = 0; address_offset = 32'hFFFF_FFF8; tick(); idle();
        total++; if (instruction_address !== 32'h08) begin bad++; $display("FAIL set_negative got %h exp %h", instruction_address, 32'h08); end
        set = 1; address_offset = 32'h40; tick(); idle();
        total++; if (instruction_address !== 32'h48) begin bad++; $display("FAIL set_positive got %h exp %h", instruction_address, 32'h48); end
        call = 1; tick(); idle();
        total++; if (instruction_address !== 32'h4C) begin bad++; $display("FAIL call_alone_pc got %h exp %h", instruction_address, 32'h4C); end
        total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL call_alone_empty got %b exp 1", ras_empty); end
    endtask

    task automatic test_call_return();
        goto(32'h20);
        jump = 1; call = 1; jump_target = 32'h400; tick(); idle();
        total++; if (instruction_address !== 32'h400) begin bad++; $display("FAIL call_pc got %h exp %h", instruction_address, 32'h400); end
        total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL call_empty got %b exp 0", ras_empty); end
        stall = 1; ret = 1; tick(); idle();
        total++; if (instruction_address !== 32'h400 || ras_empty !== 1'b0) begin bad++; $display("FAIL stall_ret got %h/%b exp 400/0", instruction_address, ras_empty); end
        tick(); tick();
        total++; if (instruction_address !== 32'h408) begin bad++; $display("FAIL call_seq got %h exp %h", instruction_address, 32'h408); end
        ret = 1; tick(); idle();
        total++; if (instruction_address !== 32'h24) begin bad++; $display("FAIL ret_pc got %h exp %h", instruction_address, 32'h24); end
        total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL ret_empty got %b exp 1", ras_empty); end
        total++; if (ras_error !== 1'b0) begin bad++; $display("FAIL ret_error got %b exp 0", ras_error); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h504; exp_ret[1] = 32'h404; exp_ret[2] = 32'h304; exp_ret[3] = 32'h204;
        goto(32'h100);
        for (int i = 0; i < 5; i++) begin
            jump = 1; call = 1; jump_target = 32'(32'h200 + 32'h100 * i); tick(); idle();
            if (i == 3) begin
                total++; if (ras_full !== 1'b1 || ras_error !== 1'b0) begin bad++; $display("FAIL fill_4 got full=%b err=%b exp full=1 err=0", ras_full, ras_error); end
            end
        end
        total++; if (ras_full !== 1'b1) begin bad++; $display("FAIL ovf_full got %b exp 1", ras_full); end
        total++; if (ras_error !== 1'b1) begin bad++; $display("FAIL ovf_error got %b exp 1", ras_error); end
        for (int i = 0; i < 4; i++) begin
            ret = 1; tick(); idle();
            total++; if (instruction_address !== exp_ret[i]) begin bad++; $display("FAIL ovf_ret_%0d got %h exp %h", i, instruction_address, exp_ret[i]); end
        end
        total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin bad++; $display("FAIL ovf_drain got empty=%b full=%b exp 1/0", ras_empty, ras_full); end
    endtask

    task automatic test_underflow_priority();
        do_reset();
        goto(32'h50);
        ret = 1; tick(); idle();
        total++; if (instruction_address !== 32'h54) begin bad++; $display("FAIL udf_pc got %h exp %h", instruction_address, 32'h54); end
        total++; if (ras_error !== 1'b1 || ras_empty !== 1'b1) begin bad++; $display("FAIL udf_flags got err=%b empty=%b exp 1/1", ras_error, ras_empty); end
        goto(32'h7C);
        jump = 1; call = 1; jump_target = 32'h1000; tick(); idle();
        ret = 1; jump = 1; call = 1; jump_target = 32'h2000; tick(); idle();
        total++; if (instruction_address !== 32'h80) begin bad++; $display("FAIL prio_pc got %h exp %h", instruction_address, 32'h80); end
        total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL prio_nopush got %b exp 1", ras_empty); end
        jump = 1; set = 1; jump_target = 32'h600; address_offset = 32'h8; tick(); idle();
        total++; if (instruction_address !== 32'h600) begin bad++; $display("FAIL jump_over_set got %h exp %h", instruction_address, 32'h600); end
    endtask

    task automatic test_wrap_reset();
        goto(32'hFFFF_FFFC);
        tick();
        total++; if (instruction_address !== 32'h0) begin bad++; $display("FAIL wrap got %h exp %h", instruction_address, 32'h0); end
        total++; if (ras_error !== 1'b1) begin bad++; $display("FAIL wrap_sticky got %b exp 1", ras_error); end
        goto(32'h30);
        jump = 1; call = 1; jump_target = 32'h300; reset = 0; tick(); idle(); reset = 1;
        total++; if (instruction_address !== 32'h0) begin bad++; $display("FAIL rst_mid_pc got %h exp %h", instruction_address, 32'h0); end
        total++; if (ras_empty !== 1'b1 || ras_error !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got empty=%b err=%b exp 1/0", ras_empty, ras_error); end
    endtask

    task automatic test_align();
        goto(32'h403);
`ifdef PC_ALIGN_CHECK_EN
        total++; if (instruction_address !== 32'h400 || misaligned !== 1'b1) begin bad++; $display("FAIL align got %h/%b exp 400/1", instruction_address, misaligned); end
        tick();
        total++; if (instruction_address !== 32'h404 || misaligned !== 1'b0) begin bad++; $display("FAIL align_pulse got %h/%b exp 404/0", instruction_address, misaligned); end
`else
        total++; if (instruction_address !== 32'h403 || misaligned !== 1'b0) begin bad++; $display("FAIL align got %h/%b exp 403/0", instruction_address, misaligned); end
        tick();
        total++; if (instruction_address !== 32'h407) begin bad++; $display("FAIL align_seq got %h exp %h", instruction_address, 32'h407); end
`endif
    endtask

    initial begin
        test_reset();
        test_stall_branch();
        test_call_return();
        test_overflow();
        test_underflow_priority();
        test_wrap_reset();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
